// File: rtl/alu_iterative_if.sv
// alu_iterative_if: issue/result bundle between the pipeline control unit and the execute ALU.
// Latency: none, this is wiring only.
// Backpressure: the ALU side drives alu_ready_out; the pipeline holds off issue while it is low.
interface alu_iterative_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_WIDTH   = 6,
    parameter int FUNCTION_WIDTH = 6
);
    logic                      alu_start_in;
    logic                      alu_flush_in;
    logic [OPCODE_WIDTH-1:0]   alu_opcode_in;
    logic [FUNCTION_WIDTH-1:0] alu_function_in;
    logic [DATA_WIDTH-1:0]     alu_data_a_in;
    logic [DATA_WIDTH-1:0]     alu_data_b_in;
    logic                      alu_ready_out;
    logic                      alu_valid_out;
    logic [DATA_WIDTH-1:0]     alu_data_out;
    logic [DATA_WIDTH-1:0]     alu_data_hi_out;
    logic                      alu_branch_result_out;
    logic                      alu_div_by_zero_out;

    // Pipeline control side: issues ops, observes results.
    modport master (
        output alu_start_in, alu_flush_in, alu_opcode_in, alu_function_in,
               alu_data_a_in, alu_data_b_in,
        input  alu_ready_out, alu_valid_out, alu_data_out, alu_data_hi_out,
               alu_branch_result_out, alu_div_by_zero_out
    );

    // ALU side: accepts ops, produces results.
    modport slave (
        input  alu_start_in, alu_flush_in, alu_opcode_in, alu_function_in,
               alu_data_a_in, alu_data_b_in,
        output alu_ready_out, alu_valid_out, alu_data_out, alu_data_hi_out,
               alu_branch_result_out, alu_div_by_zero_out
    );
endinterface

// File: rtl/alu_iterative.sv
// alu_iterative: uDLX execute-stage ALU, single-cycle ops plus iterative shift-add MULT / restoring DIV.
// Latency: single-cycle ops valid 1 clock after accept; MULT/DIV valid DATA_WIDTH+1 clocks after accept.
// Backpressure: alu_ready_out low while MULT/DIV iterate; starts while busy are dropped, flush aborts.
// Build option: define ALU_ITERATIVE_DIV_EN to include the divider; otherwise DIV returns zeros in one cycle.
module alu_iterative #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_WIDTH   = 6,
    parameter int FUNCTION_WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_iterative_if.slave alu
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Opcode / function encodings shared with the uDLX decoder.
    localparam logic [OPCODE_WIDTH-1:0]   OP_R_TYPE = OPCODE_WIDTH'('h00);
    localparam logic [OPCODE_WIDTH-1:0]   OP_BEQZ   = OPCODE_WIDTH'('h04);
    localparam logic [OPCODE_WIDTH-1:0]   OP_BNEZ   = OPCODE_WIDTH'('h05);
    localparam logic [OPCODE_WIDTH-1:0]   OP_ADDI   = OPCODE_WIDTH'('h08);
    localparam logic [OPCODE_WIDTH-1:0]   OP_SUBI   = OPCODE_WIDTH'('h0A);
    localparam logic [OPCODE_WIDTH-1:0]   OP_ANDI   = OPCODE_WIDTH'('h0C);
    localparam logic [OPCODE_WIDTH-1:0]   OP_ORI    = OPCODE_WIDTH'('h0D);
    localparam logic [OPCODE_WIDTH-1:0]   OP_LW     = OPCODE_WIDTH'('h23);
    localparam logic [OPCODE_WIDTH-1:0]   OP_SW     = OPCODE_WIDTH'('h2B);
    localparam logic [FUNCTION_WIDTH-1:0] FN_MULT   = FUNCTION_WIDTH'('h18);
    localparam logic [FUNCTION_WIDTH-1:0] FN_DIV    = FUNCTION_WIDTH'('h1A);
    localparam logic [FUNCTION_WIDTH-1:0] FN_ADD    = FUNCTION_WIDTH'('h20);
    localparam logic [FUNCTION_WIDTH-1:0] FN_SUB    = FUNCTION_WIDTH'('h22);
    localparam logic [FUNCTION_WIDTH-1:0] FN_AND    = FUNCTION_WIDTH'('h24);
    localparam logic [FUNCTION_WIDTH-1:0] FN_OR     = FUNCTION_WIDTH'('h25);
    localparam logic [FUNCTION_WIDTH-1:0] FN_NOT    = FUNCTION_WIDTH'('h27);
    localparam logic [FUNCTION_WIDTH-1:0] FN_CMP    = FUNCTION_WIDTH'('h2A);

    typedef enum logic [1:0] {
        ST_IDLE,
`ifdef ALU_ITERATIVE_DIV_EN
        ST_DIV,
`endif
        ST_MUL
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Iterative datapath: {work_hi, work_lo} is the product / remainder:quotient pair,
    // opnd is the multiplicand or divisor held for the whole operation.
    logic [W-1:0] opnd;
    logic [W-1:0] work_hi;
    logic [W-1:0] work_lo;
    logic [W-1:0] step_hi;
    logic [W-1:0] step_lo;
    logic [W:0]   mul_sum;
`ifdef ALU_ITERATIVE_DIV_EN
    logic [W:0]   div_shift;
    logic [W:0]   div_diff;
    logic         is_div;
    logic         load_div;
`endif

    // Registered outputs.
    logic [W-1:0] res_lo;
    logic [W-1:0] res_hi;
    logic         res_br;
    logic         res_dbz;
    logic         res_vld;

    // Decode of the op presented this cycle.
    logic [W-1:0] sc_lo;
    logic [W-1:0] sc_hi;
    logic         sc_br;
    logic         sc_dbz;
    logic         is_mult;

    // FSM control strobes.
    logic accept;
    logic load_mul;
    logic step_en;
    logic finish;
    logic sc_done;

    assign accept = alu.alu_start_in & (state == ST_IDLE) & ~alu.alu_flush_in;

    // Single-cycle result, branch flag and long-op detection from the issued fields.
    always_comb begin
        sc_lo   = '0;
        sc_hi   = '0;
        sc_br   = 1'b0;
        sc_dbz  = 1'b0;
        is_mult = 1'b0;
`ifdef ALU_ITERATIVE_DIV_EN
        is_div  = 1'b0;
`endif
        case (alu.alu_opcode_in)
            OP_R_TYPE: begin
                case (alu.alu_function_in)
                    FN_ADD:         sc_lo = alu.alu_data_a_in + alu.alu_data_b_in;
                    FN_SUB, FN_CMP: sc_lo = alu.alu_data_a_in - alu.alu_data_b_in;
                    FN_AND:         sc_lo = alu.alu_data_a_in & alu.alu_data_b_in;
                    FN_OR:          sc_lo = alu.alu_data_a_in | alu.alu_data_b_in;
                    FN_NOT:         sc_lo = ~alu.alu_data_b_in;
                    FN_MULT:        is_mult = 1'b1;
                    FN_DIV: begin
`ifdef ALU_ITERATIVE_DIV_EN
                        // Divide by zero is resolved immediately without entering DIV.
                        if (alu.alu_data_b_in == '0) begin
                            sc_lo  = '1;
                            sc_hi  = alu.alu_data_a_in;
                            sc_dbz = 1'b1;
                        end else begin
                            is_div = 1'b1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: sc_lo = alu.alu_data_a_in + alu.alu_data_b_in;
            OP_SUBI:               sc_lo = alu.alu_data_a_in - alu.alu_data_b_in;
            OP_ANDI:               sc_lo = alu.alu_data_a_in & alu.alu_data_b_in;
            OP_ORI:                sc_lo = alu.alu_data_a_in | alu.alu_data_b_in;
            OP_BEQZ:               sc_br = (alu.alu_data_a_in == '0);
            OP_BNEZ:               sc_br = (alu.alu_data_a_in != '0);
            default: ;
        endcase
    end

    // Next state, iteration counter and datapath strobes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_mul  = 1'b0;
        step_en   = 1'b0;
        finish    = 1'b0;
        sc_done   = 1'b0;
`ifdef ALU_ITERATIVE_DIV_EN
        load_div  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mult) begin
                        state_nxt = ST_MUL;
                        cnt_nxt   = CNT_LOAD;
                        load_mul  = 1'b1;
`ifdef ALU_ITERATIVE_DIV_EN
                    end else if (is_div) begin
                        state_nxt = ST_DIV;
                        cnt_nxt   = CNT_LOAD;
                        load_div  = 1'b1;
`endif
                    end else begin
                        sc_done = 1'b1;
                    end
                end
            end
            default: begin
                // Any iterating state: abort on flush, else retire one bit.
                if (alu.alu_flush_in) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    step_en = 1'b1;
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        finish    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // One iteration of shift-add multiply or restoring divide on the working pair.
    always_comb begin
        mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        step_hi = mul_sum[W:1];
        step_lo = {mul_sum[0], work_lo[W-1:1]};
`ifdef ALU_ITERATIVE_DIV_EN
        div_shift = {work_hi, work_lo[W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (state == ST_DIV) begin
            if (!div_diff[W]) begin
                step_hi = div_diff[W-1:0];
                step_lo = {work_lo[W-2:0], 1'b1};
            end else begin
                step_hi = div_shift[W-1:0];
                step_lo = {work_lo[W-2:0], 1'b0};
            end
        end
`endif
    end

    // State and iteration counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Working registers: loaded on accept of a long op, advanced once per iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd    <= '0;
            work_hi <= '0;
            work_lo <= '0;
        end else if (load_mul) begin
            opnd    <= alu.alu_data_a_in;
            work_hi <= '0;
            work_lo <= alu.alu_data_b_in;
`ifdef ALU_ITERATIVE_DIV_EN
        end else if (load_div) begin
            opnd    <= alu.alu_data_b_in;
            work_hi <= '0;
            work_lo <= alu.alu_data_a_in;
`endif
        end else if (step_en) begin
            work_hi <= step_hi;
            work_lo <= step_lo;
        end
    end

    // Result registers: written only on completion, so they hold across flush and idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_lo  <= '0;
            res_hi  <= '0;
            res_br  <= 1'b0;
            res_dbz <= 1'b0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= sc_done | finish;
            if (sc_done) begin
                res_lo  <= sc_lo;
                res_hi  <= sc_hi;
                res_br  <= sc_br;
                res_dbz <= sc_dbz;
            end else if (finish) begin
                res_lo  <= step_lo;
                res_hi  <= step_hi;
                res_br  <= 1'b0;
                res_dbz <= 1'b0;
            end
        end
    end

    assign alu.alu_ready_out         = (state == ST_IDLE);
    assign alu.alu_valid_out         = res_vld;
    assign alu.alu_data_out          = res_lo;
    assign alu.alu_data_hi_out       = res_hi;
    assign alu.alu_branch_result_out = res_br;
    assign alu.alu_div_by_zero_out   = res_dbz;
endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: randomized and directed checks of alu_iterative against an arithmetic reference model.
// Latency: single-cycle ops checked at T+1, MULT/DIV at T+DATA_WIDTH+1.
// Backpressure: starts issued while busy and flush interactions are exercised explicitly.
module tb_alu_iterative;
    localparam int W = 32;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SUBI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOT  = 6'h27;
    localparam logic [5:0] FN_CMP  = 6'h2A;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_iterative_if #(.DATA_WIDTH(W), .OPCODE_WIDTH(6), .FUNCTION_WIDTH(6)) bus ();

    alu_iterative #(.DATA_WIDTH(W), .OPCODE_WIDTH(6), .FUNCTION_WIDTH(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .alu   (bus.slave)
    );

    // Observed {valid, ready, branch, dbz, hi, lo}.
    logic [2*W+3:0] obs;
    assign obs = {bus.alu_valid_out, bus.alu_ready_out, bus.alu_branch_result_out,
                  bus.alu_div_by_zero_out, bus.alu_data_hi_out, bus.alu_data_out};

    // Single-cycle op kinds used for random stimulus; 6'h01 / 6'h3F are unassigned encodings.
    logic [5:0] k_op [14] = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R,
                              OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_LW, OP_SW, 6'h3F};
    logic [5:0] k_fn [14] = '{FN_ADD, FN_SUB, FN_CMP, FN_AND, FN_OR, FN_NOT, 6'h01,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    // Reference model: what the ALU must return, and after how many cycles.
    task automatic model(input logic [5:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output logic br, output logic dbz, output int lat);
        logic [2*W-1:0] prod;
        lo = '0; hi = '0; br = 1'b0; dbz = 1'b0; lat = 1;
        if (op == OP_R) begin
            case (fn)
                FN_ADD:         lo = a + b;
                FN_SUB, FN_CMP: lo = a - b;
                FN_AND:         lo = a & b;
                FN_OR:          lo = a | b;
                FN_NOT:         lo = ~b;
                FN_MULT: begin
                    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    lo   = prod[W-1:0];
                    hi   = prod[2*W-1:W];
                    lat  = W + 1;
                end
                FN_DIV: begin
`ifdef ALU_ITERATIVE_DIV_EN
                    if (b == 0) begin
                        lo = '1; hi = a; dbz = 1'b1;
                    end else begin
                        lo = a / b; hi = a % b; lat = W + 1;
                    end
`endif
                end
                default: ;
            endcase
        end else begin
            case (op)
                OP_ADDI, OP_LW, OP_SW: lo = a + b;
                OP_SUBI:               lo = a - b;
                OP_ANDI:               lo = a & b;
                OP_ORI:                lo = a | b;
                OP_BEQZ:               br = (a == 0);
                OP_BNEZ:               br = (a != 0);
                default: ;
            endcase
        end
    endtask

    task automatic drive(input logic start, input logic flush, input logic [5:0] op,
                         input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.alu_start_in    = start;
        bus.alu_flush_in    = flush;
        bus.alu_opcode_in   = op;
        bus.alu_function_in = fn;
        bus.alu_data_a_in   = a;
        bus.alu_data_b_in   = b;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, OP_R, FN_ADD, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", obs, {1'b0, 1'b1, 2'b00, {2*W{1'b0}}});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_cycle();
        logic [5:0] d_op [13] = '{OP_R, OP_R, OP_R, OP_ORI, OP_R, OP_R, OP_R,
                                  OP_R, OP_SUBI, OP_ANDI, OP_LW, OP_SW, 6'h3F};
        logic [5:0] d_fn [13] = '{FN_ADD, FN_AND, FN_NOT, 6'h00, FN_SUB, FN_CMP, FN_OR,
                                  6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        logic [W-1:0] d_a [13] = '{32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h1234_5678, 32'h0F0F_0000,
                                   32'h5, 32'h10, 32'hA000_0005, 32'h1, 32'h3, 32'hFF, 32'h100,
                                   32'hFFFF_FFF0, 32'h7};
        logic [W-1:0] d_b [13] = '{32'h1, 32'hFF00_FF00, 32'h0, 32'h0000_00F0,
                                   32'h7, 32'h3, 32'h0500_0050, 32'h1, 32'h5, 32'h0F, 32'h24,
                                   32'h20, 32'h9};
        logic [5:0] op, fn;
        logic [W-1:0] a, b, e_lo, e_hi;
        logic e_br, e_dbz;
        int lat, k;
        // Issued back-to-back: a result must appear every cycle.
        for (int i = 0; i < 13 + 40; i++) begin
            if (i < 13) begin
                op = d_op[i]; fn = d_fn[i]; a = d_a[i]; b = d_b[i];
            end else begin
                k  = $urandom_range(0, 13);
                op = k_op[k];
                fn = (op == OP_R) ? k_fn[k] : 6'($urandom);
                a  = $urandom;
                b  = $urandom;
            end
            model(op, fn, a, b, e_lo, e_hi, e_br, e_dbz, lat);
            drive(1'b1, 1'b0, op, fn, a, b);
            @(posedge clk); #1;
            checks++;
            if (obs !== {1'b1, 1'b1, e_br, e_dbz, e_hi, e_lo}) begin
                errors++;
                $display("FAIL single_cycle[%0d] op=%h fn=%h a=%h b=%h: got %h required %h",
                         i, op, fn, a, b, obs, {1'b1, 1'b1, e_br, e_dbz, e_hi, e_lo});
            end
        end
        drive(1'b0, 1'b0, OP_R, FN_ADD, '0, '0);
        @(posedge clk); #1;
        checks++;
        if (bus.alu_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle_idle_valid: got %b required 0", bus.alu_valid_out);
        end
    endtask

    task automatic test_mult();
        logic [W-1:0] a, b, e_lo, e_hi;
        logic e_br, e_dbz;
        int lat;
        for (int n = 0; n < 5; n++) begin
            case (n)
                0:       begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
                1:       begin a = 32'h0001_0000; b = 32'h0001_0000; end
                2:       begin a = $urandom;      b = 32'h0; end
                default: begin a = $urandom;      b = $urandom; end
            endcase
            model(OP_R, FN_MULT, a, b, e_lo, e_hi, e_br, e_dbz, lat);
            drive(1'b1, 1'b0, OP_R, FN_MULT, a, b);
            @(posedge clk); #1;
            // An ADD held on start while busy must not be taken until the completion cycle.
            drive(1'b1, 1'b0, OP_R, FN_ADD, 32'h11, 32'h22);
            for (int k = 1; k < lat; k++) begin
                checks++;
                if ({bus.alu_valid_out, bus.alu_ready_out} !== 2'b00) begin
                    errors++;
                    $display("FAIL mult_busy[%0d] T+%0d: valid,ready got %b required 00",
                             n, k, {bus.alu_valid_out, bus.alu_ready_out});
                end
                @(posedge clk); #1;
            end
            checks++;
            if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, e_hi, e_lo}) begin
                errors++;
                $display("FAIL mult_result[%0d] %h*%h: got %h required %h",
                         n, a, b, obs, {1'b1, 1'b1, 2'b00, e_hi, e_lo});
            end
            @(posedge clk); #1;
            drive(1'b0, 1'b0, OP_R, FN_ADD, '0, '0);
            checks++;
            if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, {W{1'b0}}, 32'h33}) begin
                errors++;
                $display("FAIL mult_accept_on_done[%0d]: got %h required %h",
                         n, obs, {1'b1, 1'b1, 2'b00, {W{1'b0}}, 32'h33});
            end
            @(posedge clk); #1;
            checks++;
            if ({bus.alu_valid_out, bus.alu_data_out} !== {1'b0, 32'h33}) begin
                errors++;
                $display("FAIL hold_after_valid[%0d]: got %h required %h",
                         n, {bus.alu_valid_out, bus.alu_data_out}, {1'b0, 32'h33});
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] a, b, e_lo, e_hi;
        logic e_br, e_dbz;
        int lat;
        for (int n = 0; n < 7; n++) begin
            case (n)
                0:       begin a = 32'd100;  b = 32'd7; end
                1:       begin a = 32'd9;    b = 32'd0; end
                2:       begin a = 32'd5;    b = 32'd9; end
                3:       begin a = $urandom; b = 32'd1; end
                4:       begin a = $urandom; b = 32'hFFFF_FFFF; end
                5:       begin a = $urandom; b = $urandom_range(1, 1000); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            model(OP_R, FN_DIV, a, b, e_lo, e_hi, e_br, e_dbz, lat);
            drive(1'b1, 1'b0, OP_R, FN_DIV, a, b);
            @(posedge clk); #1;
            drive(1'b0, 1'b0, OP_R, FN_ADD, '0, '0);
            for (int k = 1; k < lat; k++) begin
                checks++;
                if ({bus.alu_valid_out, bus.alu_ready_out} !== 2'b00) begin
                    errors++;
                    $display("FAIL div_busy[%0d] T+%0d: valid,ready got %b required 00",
                             n, k, {bus.alu_valid_out, bus.alu_ready_out});
                end
                @(posedge clk); #1;
            end
            checks++;
            if (obs !== {1'b1, 1'b1, 1'b0, e_dbz, e_hi, e_lo}) begin
                errors++;
                $display("FAIL div_result[%0d] %h/%h at T+%0d: got %h required %h",
                         n, a, b, lat, obs, {1'b1, 1'b1, 1'b0, e_dbz, e_hi, e_lo});
            end
            @(posedge clk); #1;
            checks++;
            if (bus.alu_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL div_valid_pulse[%0d]: got %b required 0", n, bus.alu_valid_out);
            end
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] a, b, e_lo, e_hi;
        logic e_br, e_dbz, saw_vld;
        int lat;
        drive(1'b1, 1'b0, OP_R, FN_ADD, 32'h1000, 32'h0234);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, OP_R, FN_ADD, '0, '0);
        // Abort a MULT at T+10.
        a = $urandom | 32'h1; b = $urandom | 32'h1;
        drive(1'b1, 1'b0, OP_R, FN_MULT, a, b);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, OP_R, FN_ADD, '0, '0);
        repeat (9) begin @(posedge clk); #1; end
        bus.alu_flush_in = 1'b1;
        @(posedge clk); #1;
        bus.alu_flush_in = 1'b0;
        checks++;
        if ({bus.alu_valid_out, bus.alu_ready_out, bus.alu_data_hi_out, bus.alu_data_out}
            !== {1'b0, 1'b1, {W{1'b0}}, 32'h1234}) begin
            errors++;
            $display("FAIL flush_abort T+11: valid,ready,hi,lo got %h required %h",
                     {bus.alu_valid_out, bus.alu_ready_out, bus.alu_data_hi_out, bus.alu_data_out},
                     {1'b0, 1'b1, {W{1'b0}}, 32'h1234});
        end
        saw_vld = 1'b0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (bus.alu_valid_out || !bus.alu_ready_out) saw_vld = 1'b1;
        end
        checks++;
        if (saw_vld !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_late_valid: activity seen %b required 0", saw_vld);
        end
        // Flush and start together: the start is dropped.
        drive(1'b1, 1'b1, OP_R, FN_ADD, 32'h5, 32'h6);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, OP_R, FN_MULT, 32'h5, 32'h6);
        checks++;
        if ({bus.alu_valid_out, bus.alu_data_out} !== {1'b0, 32'h1234}) begin
            errors++;
            $display("FAIL flush_start_add: valid,lo got %h required %h",
                     {bus.alu_valid_out, bus.alu_data_out}, {1'b0, 32'h1234});
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, OP_R, FN_ADD, '0, '0);
        checks++;
        if ({bus.alu_valid_out, bus.alu_ready_out} !== 2'b01) begin
            errors++;
            $display("FAIL flush_start_mult: valid,ready got %b required 01",
                     {bus.alu_valid_out, bus.alu_ready_out});
        end
        // Flush raised in the completion cycle leaves that valid intact.
        model(OP_R, FN_MULT, a, b, e_lo, e_hi, e_br, e_dbz, lat);
        drive(1'b1, 1'b0, OP_R, FN_MULT, a, b);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, OP_R, FN_ADD, '0, '0);
        repeat (lat - 1) begin @(posedge clk); #1; end
        bus.alu_flush_in = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, e_hi, e_lo}) begin
            errors++;
            $display("FAIL flush_on_done: got %h required %h", obs, {1'b1, 1'b1, 2'b00, e_hi, e_lo});
        end
        @(posedge clk); #1;
        bus.alu_flush_in = 1'b0;
    endtask

    task automatic test_branch();
        logic [5:0] d_op [5] = '{OP_BEQZ, OP_BNEZ, OP_BNEZ, OP_ADDI, OP_BEQZ};
        logic [W-1:0] d_a [5] = '{32'h0, 32'h0, 32'h3, 32'h0, 32'h7};
        logic [5:0] op;
        logic [W-1:0] a, b, e_lo, e_hi;
        logic e_br, e_dbz;
        int lat;
        for (int i = 0; i < 5 + 20; i++) begin
            if (i < 5) begin
                op = d_op[i]; a = d_a[i]; b = 32'h5;
            end else begin
                op = ($urandom_range(0, 1) == 0) ? OP_BEQZ : OP_BNEZ;
                a  = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom);
                b  = $urandom;
            end
            model(op, 6'h00, a, b, e_lo, e_hi, e_br, e_dbz, lat);
            drive(1'b1, 1'b0, op, 6'h00, a, b);
            @(posedge clk); #1;
            checks++;
            if ({bus.alu_valid_out, bus.alu_branch_result_out, bus.alu_data_out} !== {1'b1, e_br, e_lo}) begin
                errors++;
                $display("FAIL branch[%0d] op=%h a=%h: valid,br,lo got %h required %h", i, op, a,
                         {bus.alu_valid_out, bus.alu_branch_result_out, bus.alu_data_out}, {1'b1, e_br, e_lo});
            end
        end
        drive(1'b0, 1'b0, OP_R, FN_ADD, '0, '0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mult();
        drive(1'b1, 1'b0, OP_R, FN_ADD, 32'hAAAA_0000, 32'h5555);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, OP_R, FN_MULT, 32'hDEAD_BEEF, 32'h1234_5678);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, OP_R, FN_ADD, '0, '0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_mid_mult: got %h required %h", obs, {1'b0, 1'b1, 2'b00, {2*W{1'b0}}});
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, OP_R, FN_ADD, 32'd5, 32'd7);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, OP_R, FN_ADD, '0, '0);
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, {W{1'b0}}, 32'd12}) begin
            errors++;
            $display("FAIL first_add_after_reset: got %h required %h",
                     obs, {1'b1, 1'b1, 2'b00, {W{1'b0}}, 32'd12});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single_cycle();
        test_mult();
        test_div();
        test_flush();
        test_branch();
        test_reset_mid_mult();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_iterative.md
# alu_iterative

Multi-cycle, parametrised execute-stage ALU for the uDLX core. Single-cycle ops complete with a registered result one clock after issue. MULT and DIV run on iterative shift-add and restoring-division datapaths that also return a high-word / remainder result. A start/ready/valid handshake and a flush input let the pipeline control unit stall on long ops and abort them on branch redirect.

## Interface
- DATA_WIDTH, 32, operand/result width (≥4, even)
- OPCODE_WIDTH, 6, opcode field width
- FUNCTION_WIDTH, 6, R-type function field width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_start_in  input  1  issue request; accepted only when alu_ready_out=1
- alu_flush_in  input  1  synchronous abort of any in-flight op
- alu_opcode_in  input  OPCODE_WIDTH  opcode, sampled on accept
- alu_function_in  input  FUNCTION_WIDTH  function, sampled on accept
- alu_data_a_in  input  DATA_WIDTH  operand A, sampled on accept
- alu_data_b_in  input  DATA_WIDTH  operand B, sampled on accept
- alu_ready_out  output  1  can accept an op this cycle
- alu_valid_out  output  1  one-cycle pulse: results valid
- alu_data_out  output  DATA_WIDTH  result / product low / quotient
- alu_data_hi_out  output  DATA_WIDTH  product high / remainder, else 0
- alu_branch_result_out  output  1  branch-taken flag
- alu_div_by_zero_out  output  1  DIV with B=0, qualified by valid

## Operation
- Encodings come from the shared opcodes.v include.
- States: IDLE, MUL, DIV. alu_ready_out=1 only in IDLE.
- Accept = alu_start_in & alu_ready_out & ~alu_flush_in. Start while not ready is ignored, not queued.
- R_TYPE single-cycle functions, all unsigned:
  - ADD: a+b
  - SUB, CMP: a−b
  - AND: bitwise a&b
  - OR: bitwise a|b
  - NOT: ~b
  - Any other function: 0
- Arithmetic wraps modulo 2^DATA_WIDTH.
- I-type ops:
  - ADDI, LW, SW: a+b
  - SUBI: a−b
  - ANDI: a&b (bitwise)
  - ORI: a|b (bitwise)
  - Other opcodes: 0
- Branch: BEQZ → (a==0), BNEZ → (a!=0), else 0. Registered with the result.
- MULT: IDLE→MUL. Unsigned shift-add, one bit per cycle, counter = DATA_WIDTH. Full 2·DATA_WIDTH product: low → alu_data_out, high → alu_data_hi_out.
- DIV, B≠0: IDLE→DIV. Unsigned restoring, one bit per cycle. Quotient → alu_data_out, remainder → alu_data_hi_out.
- DIV, B=0: stays IDLE, single-cycle. Result all-ones, hi = A, alu_div_by_zero_out=1.
- Iterative completion: state→IDLE, valid pulses.
- Flush: state→IDLE next cycle. Counter cleared, valid suppressed, result registers unchanged.
- alu_data_out, alu_data_hi_out, alu_branch_result_out hold their last values until the next completion.
- Reset (rst_n=0, asynchronous): state IDLE, ready=1, valid=0, all data/flag outputs 0.

## Timing
- Accept at edge T. Single-cycle op: valid=1 and outputs updated in cycle T+1; ready stays 1, so back-to-back issue gives one result per cycle.
- Iterative op:
  - ready=0 for cycles T+1..T+DATA_WIDTH.
  - valid=1 and ready=1 in cycle T+DATA_WIDTH+1.
  - A new start in that cycle is accepted.
- Flush and start in the same cycle: flush wins, start dropped.
- Flush asserted in a completion cycle does not retract that cycle's valid.
- rst_n deassertion mid-operation: block is already IDLE. The first accept is possible on the first edge after deassertion.
- No combinational path from inputs to any output.

## Configuration
- ALU_ITERATIVE_DIV_EN defined: DIV datapath and DIV state present, as above.
- Not defined: no DIV state or divider logic. DIV completes single-cycle with alu_data_out=0, alu_data_hi_out=0, alu_div_by_zero_out=0.
- MULT and all other ops are identical in both builds.

## Test plan
- Reset: rst_n low mid-MULT → ready=1, valid=0, all outputs 0 immediately; first ADD after release 5+7 → 12 at T+1.
- Back-to-back single-cycle: ADD FFFFFFFF+1 → 0; AND F0F0F0F0&FF00FF00 → F000F000; NOT b=0 → FFFFFFFF; ORI → bitwise. Valid every cycle.
- MULT FFFFFFFF×FFFFFFFF → lo 00000001, hi FFFFFFFE. Valid exactly at T+33, ready low T+1..T+32, start during busy ignored.
- DIV 100/7 → quotient 14, remainder 2 at T+33. DIV 9/0 → FFFFFFFF, hi 9, div_by_zero=1 at T+1. Without ALU_ITERATIVE_DIV_EN → 0/0/0 at T+1.
- Flush at T+10 of MULT → no valid, ready=1 at T+11, outputs retain previous values. Flush+start same cycle → dropped.
- Branch: BEQZ a=0 → 1, BNEZ a=0 → 0, BNEZ a=3 → 1, ADDI → 0.
